// File: rtl/tlb_op_ctrl_if.sv
// Bus bundle between the TLB instruction controller and its pipeline, TLB and CP0 neighbours.
// slave = controller side, master = surrounding pipeline / TLB / CP0 side.
interface tlb_op_ctrl_if #(
  parameter int TLBNUM_WIDTH = 4
);
  logic                    op_valid;
  logic [1:0]              op_type;
  logic                    op_ready;
  logic                    flush;
  logic [31:0]             cp0_entryhi;
  logic [TLBNUM_WIDTH-1:0] cp0_index;
  logic [31:0]             cp0_entrylo0;
  logic [31:0]             cp0_entrylo1;
  logic                    s_req;
  logic [18:0]             s_vpn2;
  logic [7:0]              s_asid;
  logic                    s_found;
  logic [TLBNUM_WIDTH-1:0] s_index;
  logic                    r_req;
  logic [TLBNUM_WIDTH-1:0] r_index;
  logic [31:0]             r_entryhi;
  logic [31:0]             r_entrylo0;
  logic [31:0]             r_entrylo1;
  logic                    w_en;
  logic [TLBNUM_WIDTH-1:0] w_index;
  logic [31:0]             w_entryhi;
  logic [31:0]             w_entrylo0;
  logic [31:0]             w_entrylo1;
  logic                    cp0_index_we;
  logic                    cp0_index_p;
  logic [TLBNUM_WIDTH-1:0] cp0_index_val;
  logic                    cp0_entry_we;
  logic [31:0]             cp0_entryhi_val;
  logic [31:0]             cp0_entrylo0_val;
  logic [31:0]             cp0_entrylo1_val;
  logic                    done;
  logic                    refetch;

  modport slave (
    input  op_valid, op_type, flush, cp0_entryhi, cp0_index, cp0_entrylo0, cp0_entrylo1,
           s_found, s_index, r_entryhi, r_entrylo0, r_entrylo1,
    output op_ready, s_req, s_vpn2, s_asid, r_req, r_index,
           w_en, w_index, w_entryhi, w_entrylo0, w_entrylo1,
           cp0_index_we, cp0_index_p, cp0_index_val,
           cp0_entry_we, cp0_entryhi_val, cp0_entrylo0_val, cp0_entrylo1_val,
           done, refetch
  );

  modport master (
    output op_valid, op_type, flush, cp0_entryhi, cp0_index, cp0_entrylo0, cp0_entrylo1,
           s_found, s_index, r_entryhi, r_entrylo0, r_entrylo1,
    input  op_ready, s_req, s_vpn2, s_asid, r_req, r_index,
           w_en, w_index, w_entryhi, w_entrylo0, w_entrylo1,
           cp0_index_we, cp0_index_p, cp0_index_val,
           cp0_entry_we, cp0_entryhi_val, cp0_entrylo0_val, cp0_entrylo1_val,
           done, refetch
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for MIPS TLBP/TLBR/TLBWI/TLBWR against a TLB search/read/write port and CP0.
// Define TLB_OP_CTRL_TLBWR_EN to enable the free-running random index used by TLBWR.
module tlb_op_ctrl #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  tlb_op_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_PROBE_RSP, S_READ, S_READ_RSP, S_WRITE, S_DONE
  } state_t;

  state_t                  r_state;
  logic                    r_ready;
  logic                    r_s_req;
  logic                    r_r_req;
  logic                    r_w_en;
  logic                    r_idx_we;
  logic                    r_ent_we;
  logic                    r_done;
  logic                    r_refetch;
  logic                    w_kill;
  logic [TLBNUM_WIDTH-1:0] w_w_index;
  logic                    w_unused_ok;

`ifdef TLB_OP_CTRL_TLBWR_EN
  logic [TLBNUM_WIDTH-1:0] r_rand;
  logic                    r_rand_sel;

  // TLBNUM is a power of two, so plain modular decrement wraps 0 -> TLBNUM-1.
  always_ff @(posedge clk) begin
    if (reset) r_rand <= TLBNUM_WIDTH'(TLBNUM - 1);
    else       r_rand <= r_rand - TLBNUM_WIDTH'(1);
  end

  assign w_w_index = r_rand_sel ? r_rand : bus.cp0_index;
`else
  assign w_w_index = bus.cp0_index;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_s_req   <= 1'b0;
      r_r_req   <= 1'b0;
      r_w_en    <= 1'b0;
      r_idx_we  <= 1'b0;
      r_ent_we  <= 1'b0;
      r_done    <= 1'b0;
      r_refetch <= 1'b0;
`ifdef TLB_OP_CTRL_TLBWR_EN
      r_rand_sel <= 1'b0;
`endif
    end else begin
      r_s_req   <= 1'b0;
      r_r_req   <= 1'b0;
      r_w_en    <= 1'b0;
      r_idx_we  <= 1'b0;
      r_ent_we  <= 1'b0;
      r_done    <= 1'b0;
      r_refetch <= 1'b0;
      r_ready   <= 1'b0;
      if (bus.flush && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.op_valid && !bus.flush) begin
              case (bus.op_type)
                2'd0: begin r_state <= S_PROBE; r_s_req <= 1'b1; end
                2'd1: begin r_state <= S_READ;  r_r_req <= 1'b1; end
                2'd2: begin r_state <= S_WRITE; r_w_en  <= 1'b1; end
                default: begin
`ifdef TLB_OP_CTRL_TLBWR_EN
                  r_state <= S_WRITE;
                  r_w_en  <= 1'b1;
`else
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
`endif
                end
              endcase
`ifdef TLB_OP_CTRL_TLBWR_EN
              r_rand_sel <= (bus.op_type == 2'd3);
`endif
            end else begin
              r_ready <= 1'b1;
            end
          end
          S_PROBE:     begin r_state <= S_PROBE_RSP; r_idx_we <= 1'b1; end
          S_PROBE_RSP: begin r_state <= S_DONE;      r_done   <= 1'b1; end
          S_READ:      begin r_state <= S_READ_RSP;  r_ent_we <= 1'b1; end
          S_READ_RSP:  begin r_state <= S_DONE;      r_done   <= 1'b1; end
          S_WRITE: begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_refetch <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // A flush or reset in the same cycle must suppress every side effect immediately.
  assign w_kill       = reset | bus.flush;
  assign bus.op_ready = r_ready & ~bus.flush;

  assign bus.s_req  = r_s_req & ~w_kill;
  assign bus.s_vpn2 = bus.cp0_entryhi[31:13];
  assign bus.s_asid = bus.cp0_entryhi[7:0];

  assign bus.r_req   = r_r_req & ~w_kill;
  assign bus.r_index = bus.cp0_index;

  assign bus.w_en       = r_w_en & ~w_kill;
  assign bus.w_index    = w_w_index;
  assign bus.w_entryhi  = bus.cp0_entryhi;
  assign bus.w_entrylo0 = bus.cp0_entrylo0;
  assign bus.w_entrylo1 = bus.cp0_entrylo1;

  assign bus.cp0_index_we  = r_idx_we & ~w_kill;
  assign bus.cp0_index_p   = bus.cp0_index_we & ~bus.s_found;
  assign bus.cp0_index_val = (bus.cp0_index_we && bus.s_found) ? bus.s_index : '0;

  assign bus.cp0_entry_we     = r_ent_we & ~w_kill;
  assign bus.cp0_entryhi_val  = bus.r_entryhi;
  assign bus.cp0_entrylo0_val = bus.r_entrylo0;
  assign bus.cp0_entrylo1_val = bus.r_entrylo1;

  assign bus.done    = r_done & ~w_kill;
  assign bus.refetch = r_refetch & ~w_kill;

  assign w_unused_ok = ^bus.cp0_entryhi[12:8];

endmodule
